// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
//   Shares one SPI link between two word-access requesters. A round-robin
//   arbiter grants one request at a time. Each grant runs one complete SPI
//   transaction: command byte, 32-bit address, then 32 write-data bits, or
//   DUMMY_CYCLES dummy clocks followed by 32 read-data bits. Bits are sent
//   MSB first. sdo changes on the first clk cycle of a bit, sck rises
//   CLK_DIV cycles later (sdi is sampled on that edge), and sck falls after
//   another CLK_DIV cycles.
//
// Handshake: a requester raises req_valid[i] and holds we/addr/wdata stable.
//   req_ready[i] is high for exactly one cycle, in the IDLE cycle where the
//   request is accepted. The request fields are captured on the clock edge
//   that ends that cycle. rsp_valid[i] is high for one cycle, the last HOLD
//   cycle. For reads, rsp_rdata is already valid in that cycle and stays
//   valid until the next read completes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/we      per-requester request and direction (1 = write)
//   req_addr/wdata    per-requester address / write data, [32*i +: 32]
//   req_ready         acceptance pulse per requester
//   rsp_valid         completion pulse per requester
//   rsp_rdata         last word read from the slave
//   busy              FSM not in IDLE
//   spi_csn/sck/sdo   SPI pins, driven from flops
//   spi_sdi           SPI master-in data
//   dbg_state         current FSM state, for observation
module spi_master_arbiter #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned DUMMY_CYCLES = 33,
  parameter int unsigned GAP_CYCLES   = 8,
  parameter logic [7:0]  CMD_WR       = 8'h02,
  parameter logic [7:0]  CMD_RD       = 8'h0B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_sdo,
  input  logic        spi_sdi,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_HOLD, S_GAP
  } state_e;

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_MAX = (DUMMY_CYCLES > 32) ? DUMMY_CYCLES : 32;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX);
  localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_CMD   = BIT_W'(7);
  localparam logic [BIT_W-1:0] LAST_WORD  = BIT_W'(31);
  localparam logic [BIT_W-1:0] LAST_DUMMY =
    BIT_W'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               half_q, half_d;     // 0: sck-low half, 1: sck-high half
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               ptr_q, ptr_d;       // requester favored on a tie
  logic               gnt_q, gnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rx_q, rx_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               csn_q, csn_d;
  logic               sck_q, sck_d;
  logic               sdo_q, sdo_d;

  logic               tick;
  logic               bit_end;
  logic               shift_q_st;
  logic               shift_d_st;
  logic               sel;
  logic [7:0]         cmd_byte;

  // One bit time is two halves of CLK_DIV cycles each. SETUP and HOLD reuse
  // the same counters, so each of them lasts exactly one bit time.
  assign tick     = (div_q == DIV_LAST);
  assign bit_end  = tick && half_q;
  assign cmd_byte = we_q ? CMD_WR : CMD_RD;

  assign shift_q_st = (state_q == S_CMD) || (state_q == S_ADDR) ||
                      (state_q == S_WDATA) || (state_q == S_DUMMY) ||
                      (state_q == S_RDATA);
  assign shift_d_st = (state_d == S_CMD) || (state_d == S_ADDR) ||
                      (state_d == S_WDATA) || (state_d == S_DUMMY) ||
                      (state_d == S_RDATA);

  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    half_d    = tick ? ~half_q : half_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    sel       = 1'b0;

    // sdi is sampled on the edge where sck goes 0->1.
    if (state_q == S_RDATA && tick && !half_q) begin
      rx_d = {rx_q[30:0], spi_sdi};
    end

    case (state_q)
      S_IDLE: begin
        div_d  = '0;
        half_d = 1'b0;
        bit_d  = '0;
        gap_d  = '0;
        if (!rst && (req_valid != 2'b00)) begin
          // A tie goes to the favored requester; otherwise the sole one wins.
          sel            = (req_valid == 2'b11) ? ptr_q : req_valid[1];
          req_ready[sel] = 1'b1;
          gnt_d          = sel;
          ptr_d          = ~sel;
          we_d           = sel ? req_we[1] : req_we[0];
          addr_d         = sel ? req_addr[63:32]  : req_addr[31:0];
          wdata_d        = sel ? req_wdata[63:32] : req_wdata[31:0];
          state_d        = S_SETUP;
        end
      end
      S_SETUP: begin
        if (bit_end) begin
          state_d = S_CMD;
          bit_d   = '0;
        end
      end
      S_CMD: begin
        if (bit_end) begin
          if (bit_q == LAST_CMD) begin
            state_d = S_ADDR;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (bit_end) begin
          if (bit_q == LAST_WORD) begin
            bit_d = '0;
            if (we_q) begin
              state_d = S_WDATA;
            end else if (DUMMY_CYCLES == 0) begin
              state_d = S_RDATA;
            end else begin
              state_d = S_DUMMY;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (bit_end) begin
          if (bit_q == LAST_WORD) begin
            state_d = S_HOLD;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_DUMMY: begin
        if (bit_end) begin
          if (bit_q == LAST_DUMMY) begin
            state_d = S_RDATA;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_RDATA: begin
        if (bit_end) begin
          if (bit_q == LAST_WORD) begin
            // The last sample happened mid-bit, so rx_q is complete here.
            state_d = S_HOLD;
            bit_d   = '0;
            rdata_d = rx_q;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (bit_end) begin
          rsp_valid[gnt_q] = 1'b1;
          state_d          = S_GAP;
          gap_d            = '0;
        end
      end
      S_GAP: begin
        div_d  = '0;
        half_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin values are derived from the next state, so each pin flop changes on
  // the same edge as the state/bit transition it belongs to.
  always_comb begin
    csn_d = !((state_d == S_SETUP) || (state_d == S_HOLD) || shift_d_st);
    sck_d = shift_d_st && half_d;
    sdo_d = 1'b0;
    case (state_d)
      S_CMD:   sdo_d = cmd_byte[3'd7 - bit_d[2:0]];
      S_ADDR:  sdo_d = addr_q[5'd31 - bit_d[4:0]];
      S_WDATA: sdo_d = wdata_q[5'd31 - bit_d[4:0]];
      default: sdo_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      csn_q   <= 1'b1;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      csn_q   <= csn_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign spi_csn   = csn_q;
  assign spi_sck   = sck_q;
  assign spi_sdo   = sdo_q;
  assign dbg_state = state_q;

  // Only used while a shift phase is active; kept for observation.
  logic unused_ok;
  assign unused_ok = shift_q_st;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: instance 0 uses CLK_DIV=4, instance 1 uses
// CLK_DIV=1. A pin monitor records every csn-low window. A slave model
// drives sdi. Each transaction is checked against the expected bit stream,
// latency and read data.
module tb_spi_master_arbiter;

  localparam int GAP = 8;
  localparam int DUMMY = 33;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid [2];
  logic [1:0]  req_we    [2];
  logic [63:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic [1:0]  req_ready [2];
  logic [1:0]  rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        busy      [2];
  logic        spi_csn   [2];
  logic        spi_sck   [2];
  logic        spi_sdo   [2];
  logic        spi_sdi   [2];
  logic [3:0]  dbg_state [2];

  spi_master_arbiter #(.CLK_DIV(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .spi_csn(spi_csn[0]), .spi_sck(spi_sck[0]), .spi_sdo(spi_sdo[0]),
    .spi_sdi(spi_sdi[0]), .dbg_state(dbg_state[0])
  );

  spi_master_arbiter #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .spi_csn(spi_csn[1]), .spi_sck(spi_sck[1]), .spi_sdo(spi_sdo[1]),
    .spi_sdi(spi_sdi[1]), .dbg_state(dbg_state[1])
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- pin monitor and slave model ----------------
  typedef struct {
    int           inst;
    int           rises;
    logic [127:0] bits;
    int           pmin;
    int           pmax;
    int           gap;
  } win_t;

  win_t         win_q[$];
  win_t         w_tmp;
  logic         prev_csn [2] = '{1'b1, 1'b1};
  logic         prev_sck [2] = '{1'b0, 1'b0};
  int           rises    [2] = '{0, 0};
  logic [127:0] bits     [2];
  int           hi_run   [2] = '{0, 0};
  int           gap_fall [2] = '{0, 0};
  int           last_rise[2] = '{0, 0};
  int           pmin     [2] = '{0, 0};
  int           pmax     [2] = '{0, 0};
  int           ready_cnt[2] = '{0, 0};
  int           rsp_cnt  [2] = '{0, 0};
  int           exp_ready[2] = '{0, 0};
  int           exp_rsp  [2] = '{0, 0};
  logic [31:0]  slave_word[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (spi_csn[d] === 1'b0) begin
        if (prev_csn[d] === 1'b1) begin
          rises[d]    = 0;
          bits[d]     = '0;
          pmin[d]     = 1000000;
          pmax[d]     = 0;
          gap_fall[d] = hi_run[d];
        end
        if (spi_sck[d] === 1'b1 && prev_sck[d] === 1'b0) begin
          if (rises[d] > 0) begin
            if (cyc - last_rise[d] < pmin[d]) pmin[d] = cyc - last_rise[d];
            if (cyc - last_rise[d] > pmax[d]) pmax[d] = cyc - last_rise[d];
          end
          last_rise[d] = cyc;
          rises[d]     = rises[d] + 1;
          bits[d]      = {bits[d][126:0], spi_sdo[d]};
        end
        hi_run[d] = 0;
      end else begin
        if (prev_csn[d] === 1'b0) begin
          w_tmp.inst  = d;
          w_tmp.rises = rises[d];
          w_tmp.bits  = bits[d];
          w_tmp.pmin  = pmin[d];
          w_tmp.pmax  = pmax[d];
          w_tmp.gap   = gap_fall[d];
          win_q.push_back(w_tmp);
        end
        hi_run[d] = hi_run[d] + 1;
      end
      prev_csn[d] = spi_csn[d];
      prev_sck[d] = spi_sck[d];
      if (req_ready[d] !== 2'b00) ready_cnt[d] = ready_cnt[d] + $countones(req_ready[d]);
      if (rsp_valid[d] !== 2'b00) rsp_cnt[d] = rsp_cnt[d] + $countones(rsp_valid[d]);
      // The slave presents read data for the rises after command, address
      // and dummy clocks; every other rise gets a random bit.
      if (spi_csn[d] === 1'b0 && rises[d] >= 40 + DUMMY && rises[d] < 72 + DUMMY)
        spi_sdi[d] = slave_word[d][31 - (rises[d] - 40 - DUMMY)];
      else
        spi_sdi[d] = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // One bit time per SETUP and HOLD, 72 shifted bits, plus dummies on reads.
  function automatic int lat_of(input int d, input bit we);
    return 2 * div_of(d) * (2 + 72 + (we ? 0 : DUMMY));
  endfunction

  task automatic get_win(output win_t w, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (win_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (win_q.size() > 0) begin
      w  = win_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic chk_txn(input int d, input int g, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] sword, input int t_acc);
    bit          got;
    bit          ok;
    int          n;
    int          t_rsp;
    win_t        w;
    logic [1:0]  oh;
    logic [71:0] exp_wr;
    logic [72:0] exp_rd;
    got   = 1'b0;
    n     = 0;
    t_rsp = 0;
    oh    = 2'b01 << g;
    while (!got && n < 3000) begin
      @(negedge clk);
      n++;
      if (rsp_valid[d][g] === 1'b1) begin
        got   = 1'b1;
        t_rsp = cyc;
      end
    end
    chk("rsp_seen", got, 1);
    exp_rsp[d]++;
    if (got) begin
      chk("rsp_onehot", rsp_valid[d], oh);
      chk("latency", t_rsp - t_acc, lat_of(d, we));
      if (!we) chk("rdata", rsp_rdata[d], sword);
    end
    get_win(w, ok);
    chk("window_seen", ok, 1);
    if (ok) begin
      chk("window_inst", w.inst, d);
      chk("sck_rises", w.rises, we ? 72 : 72 + DUMMY);
      exp_wr = {(we ? 8'h02 : 8'h0B), addr, wdata};
      exp_rd = {8'h0B, addr, 33'b0};
      if (we) chk("sdo_stream", w.bits[71:0], exp_wr);
      else    chk("sdo_stream", w.bits[72+DUMMY-1:32], exp_rd);
      chk("sck_period_min", w.pmin, 2 * div_of(d));
      chk("sck_period_max", w.pmax, 2 * div_of(d));
      chk("csn_gap", w.gap >= GAP, 1);
    end
  endtask

  task automatic do_txn(input int d, input int r, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] sword, input bit mutate);
    bit got;
    int n;
    int t_acc;
    slave_word[d] = sword;
    @(posedge clk); #1;
    req_we[d][r]              = we;
    req_addr[d][32*r +: 32]   = addr;
    req_wdata[d][32*r +: 32]  = wdata;
    req_valid[d][r]           = 1'b1;
    got   = 1'b0;
    n     = 0;
    t_acc = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (req_ready[d][r] === 1'b1) begin
        got   = 1'b1;
        t_acc = cyc;
      end
    end
    chk("accept", got, 1);
    exp_ready[d]++;
    @(posedge clk); #1;
    req_valid[d][r] = 1'b0;
    if (mutate) begin
      req_addr[d][32*r +: 32]  = ~addr;
      req_wdata[d][32*r +: 32] = $urandom;
      req_we[d][r]             = ~we;
    end
    @(negedge clk);
    chk("busy", busy[d], 1);
    chk_txn(d, r, we, addr, wdata, sword, t_acc);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] a0, a1, d0, s1, ra, rd, rs;
    bit          rwe;
    int          rr;
    int          ptr_m;
    int          exp_g;
    int          n;
    int          t_acc;
    bit          got;
    bit          ok;
    logic [1:0]  seen;
    logic [1:0]  exp_oh;
    win_t        w;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 2'b00;
      req_we[d]    = 2'b00;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      slave_word[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_csn", spi_csn[d], 1);
      chk("rst_sck", spi_sck[d], 0);
      chk("rst_sdo", spi_sdo[d], 0);
      chk("rst_ready", req_ready[d], 0);
      chk("rst_rsp_valid", rsp_valid[d], 0);
      chk("rst_rdata", rsp_rdata[d], 0);
      chk("rst_busy", busy[d], 0);
    end
    rst = 1'b0;
    repeat (12) @(posedge clk);

    // Directed write and read from the two requesters.
    do_txn(0, 0, 1'b1, 32'h1A10_0000, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_txn(0, 1, 1'b0, 32'h1C00_0008, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Request fields change right after acceptance.
    do_txn(0, 0, 1'b1, 32'h1234_5678, 32'hA5A5_0F0F, 32'h0, 1'b1);

    // Randomized transactions.
    for (int i = 0; i < 3; i++) begin
      rwe = 1'($urandom_range(0, 1));
      rr  = $urandom_range(0, 1);
      ra  = $urandom;
      rd  = $urandom;
      rs  = $urandom;
      do_txn(0, rr, rwe, ra, rd, rs, 1'b0);
    end

    // Reset during the address phase of a write.
    slave_word[0] = '0;
    @(posedge clk); #1;
    req_we[0][0]         = 1'b1;
    req_addr[0][31:0]    = 32'h0BAD_F00D;
    req_wdata[0][31:0]   = 32'h1111_2222;
    req_valid[0][0]      = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (req_ready[0][0] === 1'b1) got = 1'b1;
    end
    chk("rst_mid_accept", got, 1);
    exp_ready[0]++;
    @(posedge clk); #1;
    req_valid[0][0] = 1'b0;
    repeat (150) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_csn", spi_csn[0], 1);
    chk("rst_mid_sck", spi_sck[0], 0);
    chk("rst_mid_sdo", spi_sdo[0], 0);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_rsp", rsp_valid[0], 0);
    rst = 1'b0;
    get_win(w, ok);
    chk("rst_mid_window", ok, 1);
    if (ok) chk("rst_mid_in_addr", (w.inst == 0) && (w.rises > 8) && (w.rises < 40), 1);
    repeat (900) @(negedge clk);
    chk("rst_mid_no_rsp", rsp_cnt[0], exp_rsp[0]);
    do_txn(0, 0, 1'b1, 32'h2000_0040, 32'h7654_3210, 32'h0, 1'b0);

    // CLK_DIV=1 instance: write then read back of 0x0000_0001.
    ra = $urandom;
    do_txn(1, 0, 1'b1, ra, 32'h0000_0001, 32'h0, 1'b0);
    do_txn(1, 0, 1'b0, ra, 32'h0, 32'h0000_0001, 1'b0);

    // Both requesters held valid from reset: grants alternate from 0.
    a0 = $urandom;
    d0 = $urandom;
    a1 = $urandom;
    s1 = $urandom;
    slave_word[0] = s1;
    @(posedge clk); #1;
    rst = 1'b1;
    req_we[0]    = 2'b01;
    req_addr[0]  = {a1, a0};
    req_wdata[0] = {32'h0, d0};
    req_valid[0] = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < 4; i++) begin
      got   = 1'b0;
      n     = 0;
      seen  = 2'b00;
      t_acc = 0;
      while (!got && n < 200) begin
        @(negedge clk);
        n++;
        if (req_ready[0] !== 2'b00) begin
          got   = 1'b1;
          seen  = req_ready[0];
          t_acc = cyc;
        end
      end
      exp_g  = ptr_m;
      ptr_m  = 1 - ptr_m;
      exp_oh = 2'b01 << exp_g;
      chk("rr_accept", got, 1);
      chk("rr_grant", seen, exp_oh);
      exp_ready[0]++;
      if (exp_g == 0) chk_txn(0, 0, 1'b1, a0, d0, 32'h0, t_acc);
      else            chk_txn(0, 1, 1'b0, a1, 32'h0, s1, t_acc);
    end
    @(posedge clk); #1;
    req_valid[0] = 2'b00;
    repeat (40) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk("ready_pulses", ready_cnt[d], exp_ready[d]);
      chk("rsp_pulses", rsp_cnt[d], exp_rsp[d]);
    end
    chk("stray_windows", win_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
